// File: rtl/vga_sync_pkg.sv
// rtl/vga_sync_pkg.sv - 640x480 timing constants and raw sync decode shared by the video cores
package vga_sync_pkg;

    localparam int CW = 11;

    localparam int HD = 640;
    localparam int HF = 16;
    localparam int HB = 48;
    localparam int HR = 96;
    localparam int HT = HD + HF + HB + HR;

    localparam int VD = 480;
    localparam int VF = 10;
    localparam int VB = 33;
    localparam int VR = 2;
    localparam int VT = VD + VF + VB + VR;

    typedef struct packed {
        logic hs;
        logic vs;
        logic von;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, von: 1'b0};

    function automatic sync_t raw_sync(input logic [CW-1:0] hc, input logic [CW-1:0] vc);
        sync_t s;
        s.hs  = !((hc >= CW'(HD + HF)) && (hc <= CW'(HD + HF + HR - 1)));
        s.vs  = !((vc >= CW'(VD + VF)) && (vc <= CW'(VD + VF + VR - 1)));
        s.von = (hc < CW'(HD)) && (vc < CW'(VD));
        return s;
    endfunction

endpackage

// File: rtl/vga_frame_counter.sv
// rtl/vga_frame_counter.sv - divide-by-4 pixel tick and hc/vc scan counters
module vga_frame_counter
    import vga_sync_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic          p_tick,
    output logic          p_tick_next,
    output logic          frame_last
);

    logic [1:0] div;

    assign p_tick      = (div == 2'd3);
    assign p_tick_next = (div == 2'd2);
    assign frame_last  = (hc == CW'(HT - 1)) && (vc == CW'(VT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= 2'd0;
            hc  <= '0;
            vc  <= '0;
        end else begin
            div <= div + 2'd1;
            if (p_tick) begin
                if (hc == CW'(HT - 1)) begin
                    hc <= '0;
                    vc <= (vc == CW'(VT - 1)) ? '0 : vc + CW'(1);
                end else begin
                    hc <= hc + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vga_sync_core.sv
// rtl/vga_sync_core.sv - VGA sync/blanking core; VGA_SYNC_DELAY_EN selects the DLY-stage sync delay
module vga_sync_core
    import vga_sync_pkg::*;
#(
    parameter int CD  = 12,
    parameter int DLY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic          hsync,
    output logic          vsync,
    output logic [CD-1:0] rgb,
    output logic          frame_start
);

`ifdef VGA_SYNC_DELAY_EN
    localparam int NS = DLY;
`else
    localparam int NS = 1;
`endif

    if (DLY < 1 || DLY > 7) begin : g_dly_check
        $error("vga_sync_core: DLY must be in 1..7");
    end

    logic  p_tick;
    logic  p_tick_next;
    logic  frame_last;
    sync_t raw;
    sync_t dly_q [NS];
    sync_t tail;
    logic  wr_en;
    logic  blank_reg;
    logic  blank_act;
    logic  [1:0] pol_reg;
    logic  unused_slot_bits;

    vga_frame_counter u_frame_counter (
        .clk         (clk),
        .reset       (reset),
        .hc          (hc),
        .vc          (vc),
        .p_tick      (p_tick),
        .p_tick_next (p_tick_next),
        .frame_last  (frame_last)
    );

    assign raw              = raw_sync(hc, vc);
    assign tail             = dly_q[NS-1];
    assign wr_en            = cs && write;
    assign unused_slot_bits = ^{addr[13:2], wr_data[31:2]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NS; i++) begin
                dly_q[i] <= SYNC_IDLE;
            end
        end else if (p_tick) begin
            dly_q[0] <= raw;
            for (int i = 1; i < NS; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // frame_start is decoded one clk early so the register is high in the last-pixel tick itself
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= '0;
            frame_start <= 1'b0;
            blank_reg   <= 1'b0;
            blank_act   <= 1'b0;
            pol_reg     <= 2'b00;
        end else begin
            hsync       <= tail.hs ^ pol_reg[0];
            vsync       <= tail.vs ^ pol_reg[1];
            rgb         <= (tail.von && !blank_act) ? si_rgb : '0;
            frame_start <= p_tick_next && frame_last;
            if (frame_start) begin
                blank_act <= blank_reg;
            end
            if (wr_en) begin
                case (addr[1:0])
                    2'd0:    blank_reg <= wr_data[0];
                    2'd1:    pol_reg   <= wr_data[1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_core.sv
// tb/tb_vga_sync_core.sv - directed bench for vga_sync_core with a cycle-count reference model
module tb_vga_sync_core;

    localparam int CD        = 12;
    localparam int PIX_FRAME = 800 * 525;
    localparam int FRAME_CLK = PIX_FRAME * 4;
    localparam int MAX_PRINT = 200;
`ifdef VGA_SYNC_DELAY_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int HS_F = (656 + D) * 4 + 1;
    localparam int VS_F = (392000 + D) * 4 + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cs = 1'b0;
    logic          write = 1'b0;
    logic [13:0]   addr = '0;
    logic [31:0]   wr_data = '0;
    logic [CD-1:0] si_rgb = 12'hABC;
    logic [10:0]   hc;
    logic [10:0]   vc;
    logic          hsync;
    logic          vsync;
    logic [CD-1:0] rgb;
    logic          frame_start;

    always #5 clk = ~clk;

    vga_sync_core #(.CD(CD), .DLY(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cs          (cs),
        .write       (write),
        .addr        (addr),
        .wr_data     (wr_data),
        .si_rgb      (si_rgb),
        .hc          (hc),
        .vc          (vc),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= MAX_PRINT)
                $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: every output follows from the clk count since reset release.
    int            n = 0;
    logic [1:0]    m_pol = 2'b00;
    logic          m_blank_reg = 1'b0;
    logic          m_blank_act = 1'b0;
    logic [10:0]   e_hc = '0;
    logic [10:0]   e_vc = '0;
    logic          e_hs = 1'b1;
    logic          e_vs = 1'b1;
    logic [CD-1:0] e_rgb = '0;
    logic          e_fs = 1'b0;

    function automatic logic hs_of(input int q);
        int h;
        h = (q % PIX_FRAME) % 800;
        return !(h >= 656 && h <= 751);
    endfunction

    function automatic logic vs_of(input int q);
        int v;
        v = (q % PIX_FRAME) / 800;
        return !(v == 490 || v == 491);
    endfunction

    function automatic logic von_of(input int q);
        int p;
        p = q % PIX_FRAME;
        return ((p % 800) < 640) && ((p / 800) < 480);
    endfunction

    always @(posedge clk or negedge reset) begin : model
        int   q;
        logic von;
        if (!reset) begin
            n = 0;
            m_pol = 2'b00;
            m_blank_reg = 1'b0;
            m_blank_act = 1'b0;
            e_hc = '0;
            e_vc = '0;
            e_hs = 1'b1;
            e_vs = 1'b1;
            e_rgb = '0;
            e_fs = 1'b0;
        end else begin
            q = n / 4 - D;
            if (q < 0) begin
                e_hs = 1'b1 ^ m_pol[0];
                e_vs = 1'b1 ^ m_pol[1];
                von = 1'b0;
            end else begin
                e_hs = hs_of(q) ^ m_pol[0];
                e_vs = vs_of(q) ^ m_pol[1];
                von = von_of(q);
            end
            e_rgb = (von && !m_blank_act) ? si_rgb : '0;
            if (n % FRAME_CLK == FRAME_CLK - 1)
                m_blank_act = m_blank_reg;
            if (cs && write) begin
                if (addr[1:0] == 2'd0)
                    m_blank_reg = wr_data[0];
                else if (addr[1:0] == 2'd1)
                    m_pol = wr_data[1:0];
            end
            n = n + 1;
            e_hc = 11'((n / 4) % 800);
            e_vc = 11'((n / 4 / 800) % 525);
            e_fs = (n % FRAME_CLK == FRAME_CLK - 1);
        end
    end

    always @(negedge clk) begin
        check("hc", 32'(hc), 32'(e_hc));
        check("vc", 32'(vc), 32'(e_vc));
        check("hsync", 32'(hsync), 32'(e_hs));
        check("vsync", 32'(vsync), 32'(e_vs));
        check("rgb", 32'(rgb), 32'(e_rgb));
        check("frame_start", 32'(frame_start), 32'(e_fs));
    end

    task automatic wait_n(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 2 * FRAME_CLK) begin
            @(negedge clk);
            guard++;
        end
        check("wait_bound", 32'(n >= target), 32'd1);
    endtask

    task automatic slot_write(input logic [13:0] a, input logic [31:0] d);
        cs = 1'b1;
        write = 1'b1;
        addr = a;
        wr_data = d;
        @(negedge clk);
        cs = 1'b0;
        write = 1'b0;
        addr = '0;
        wr_data = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_hc", 32'(hc), 32'd0);
        reset = 1'b1;

        wait_n(3);  check("hc_before_tick", 32'(hc), 32'd0);
        wait_n(4);  check("hc_first_tick", 32'(hc), 32'd1);
        wait_n(HS_F - 1);   check("hs_before_fall", 32'(hsync), 32'd1);
        wait_n(HS_F);       check("hs_fall", 32'(hsync), 32'd0);
        wait_n(HS_F + 383); check("hs_last_low", 32'(hsync), 32'd0);
        wait_n(HS_F + 384); check("hs_rise", 32'(hsync), 32'd1);
        wait_n(3199); check("hc_799", 32'(hc), 32'd799); check("vc_line0", 32'(vc), 32'd0);
        wait_n(3200); check("hc_wrap", 32'(hc), 32'd0);  check("vc_line1", 32'(vc), 32'd1);

        wait_n(4 * (4010 + D) + 2); check("rgb_active", 32'(rgb), 32'hABC);
        wait_n(4 * (4700 + D) + 2); check("rgb_hblank", 32'(rgb), 32'd0);
        wait_n(4 * 8000); si_rgb = 12'h5A5;
        wait_n(4 * (8820 + D) + 2); check("rgb_new_pixel", 32'(rgb), 32'h5A5);
        wait_n(4 * 9600); si_rgb = 12'hABC;

        wait_n(4 * 40000); slot_write(14'd2, 32'hFFFF_FFFF);
        wait_n(4 * (40820 + D) + 2);
        check("ignored_wr_rgb", 32'(rgb), 32'hABC);
        check("ignored_wr_hs", 32'(hsync), 32'd1);

        wait_n(4 * 80100); slot_write(14'd0, 32'd1);
        wait_n(4 * (160300 + D) + 2); check("blank_waits_frame", 32'(rgb), 32'hABC);

        wait_n(VS_F - 1);    check("vs_before_fall", 32'(vsync), 32'd1);
        wait_n(VS_F);        check("vs_fall", 32'(vsync), 32'd0);
        wait_n(VS_F + 6399); check("vs_last_low", 32'(vsync), 32'd0);
        wait_n(VS_F + 6400); check("vs_rise", 32'(vsync), 32'd1);

        wait_n(FRAME_CLK - 2); check("fs_early", 32'(frame_start), 32'd0);
        wait_n(FRAME_CLK - 1);
        check("fs_pulse", 32'(frame_start), 32'd1);
        check("fs_hc", 32'(hc), 32'd799);
        check("fs_vc", 32'(vc), 32'd524);
        slot_write(14'd0, 32'd0);
        check("fs_gone", 32'(frame_start), 32'd0);
        check("wrap_hc", 32'(hc), 32'd0);
        check("wrap_vc", 32'(vc), 32'd0);

        wait_n(FRAME_CLK + 4 * (4010 + D) + 2); check("rgb_blanked", 32'(rgb), 32'd0);

        wait_n(FRAME_CLK + 4 * 4900); slot_write(14'd1, 32'd3);
        check("pol_not_yet", 32'(hsync), 32'd1);
        @(negedge clk);
        check("pol_hs_low", 32'(hsync), 32'd0);
        check("pol_vs_low", 32'(vsync), 32'd0);

        wait_n(FRAME_CLK + 4 * 5000 + 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_hsync", 32'(hsync), 32'd1);
        check("arst_vsync", 32'(vsync), 32'd1);
        check("arst_rgb", 32'(rgb), 32'd0);
        check("arst_hc", 32'(hc), 32'd0);
        check("arst_vc", 32'(vc), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_n(4);    check("rerun_hc", 32'(hc), 32'd1);
        wait_n(3200); check("rerun_vc", 32'(vc), 32'd1); check("rerun_pol", 32'(hsync), 32'd1);
        wait_n(4 * (810 + D) + 2); check("rerun_rgb_clear", 32'(rgb), 32'hABC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
